// File: rtl/instr_encoder_if.sv
// ---------------------------------------------------------------------------
// instr_encoder_if
//  Bundles the request handshake, the instruction-memory write port and the
//  status outputs of the instruction encoder / program loader.
//  Parameter:
//   ADDR_W       word-address width of the instruction memory
//  Signals:
//   start_i      open (or restart) a load window, one-cycle pulse
//   stop_i       close the load window, one-cycle pulse
//   req_valid_i  request present; req_ready_o accepts it
//   kind_i       0=R 1=ADDI 2=ORI 3=BEQ 4=LW 5=SW 6=J 7=illegal
//   rs_i/rt_i/rd_i/shamt_i/funct_i/imm_i/target_i  instruction fields
//   mem_we_o     instruction-memory write strobe
//   mem_addr_o   write word address
//   mem_wdata_o  encoded 32-bit instruction
//   count_o      words written in the current window
//   busy_o       load window open
//   err_cnt_o    illegal requests dropped
//  Modports: master (program source / host), slave (the encoder).
// ---------------------------------------------------------------------------
interface instr_encoder_if #(
   parameter int ADDR_W = 8
);
   logic              start_i;
   logic              stop_i;
   logic              req_valid_i;
   logic              req_ready_o;
   logic [2:0]        kind_i;
   logic [4:0]        rs_i;
   logic [4:0]        rt_i;
   logic [4:0]        rd_i;
   logic [4:0]        shamt_i;
   logic [5:0]        funct_i;
   logic [15:0]       imm_i;
   logic [25:0]       target_i;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [31:0]       mem_wdata_o;
   logic [ADDR_W:0]   count_o;
   logic              busy_o;
   logic [7:0]        err_cnt_o;

   modport master (
      output start_i, stop_i, req_valid_i, kind_i, rs_i, rt_i, rd_i,
             shamt_i, funct_i, imm_i, target_i,
      input  req_ready_o, mem_we_o, mem_addr_o, mem_wdata_o, count_o,
             busy_o, err_cnt_o
   );

   modport slave (
      input  start_i, stop_i, req_valid_i, kind_i, rs_i, rt_i, rd_i,
             shamt_i, funct_i, imm_i, target_i,
      output req_ready_o, mem_we_o, mem_addr_o, mem_wdata_o, count_o,
             busy_o, err_cnt_o
   );
endinterface

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//  Program loader: packs field-level instruction requests into 32-bit MIPS
//  words (R-type, ADDI, ORI, BEQ, LW, SW, J) and writes them into the
//  instruction memory, one word per accepted request, starting at BASE_ADDR
//  each time a load window is opened.
//  Parameters:
//   ADDR_W     word-address width of the instruction memory
//   BASE_ADDR  first word address of every load window
//  Ports:
//   clk_i      clock
//   rst_i      synchronous reset, active-high
//   bus        instr_encoder_if.slave (handshake, memory port, status)
//  Configuration macro:
//   ENCODER_CHECK_EN  when defined, kind 7 requests are accepted but dropped
//                     and counted in err_cnt_o; otherwise they are written
//                     as a NOP (all zeros) and err_cnt_o is tied to 0.
// ---------------------------------------------------------------------------
module instr_encoder #(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input logic            clk_i,
   input logic            rst_i,
   instr_encoder_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_FULL
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_J    = 6'b000010;

   localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W:0]   CNT_LAST = {1'b0, {ADDR_W{1'b1}}};
   localparam logic [ADDR_W:0]   CNT_MAX  = {1'b1, {ADDR_W{1'b0}}};

   state_t            state_q;
   state_t            state_d;
   logic              req_ready;
   logic              accept;
   logic              drop;
   logic              write_en;
   logic [31:0]       enc_word;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [ADDR_W-1:0] ptr_q;
   logic [ADDR_W:0]   cnt_q;

   // Requests are only taken while loading; a start or stop in the same
   // cycle takes priority so a restarted window never begins mid-request.
   assign req_ready = (state_q == ST_LOAD) & ~bus.start_i & ~bus.stop_i;
   assign accept    = bus.req_valid_i & req_ready;

   // Illegal requests are either swallowed (checked build) or written as
   // an all-zero NOP like any other word.
`ifdef ENCODER_CHECK_EN
   assign drop = accept & (bus.kind_i == 3'd7);
`else
   assign drop = 1'b0;
`endif
   assign write_en = accept & ~drop;

   // Field packing. BEQ/LW/SW/ADDI/ORI share the I layout; kind 7 packs to 0.
   always_comb begin
      enc_word = '0;
      case (bus.kind_i)
         3'd0: enc_word = {OP_R, bus.rs_i, bus.rt_i, bus.rd_i, bus.shamt_i, bus.funct_i};
         3'd1: enc_word = {OP_ADDI, bus.rs_i, bus.rt_i, bus.imm_i};
         3'd2: enc_word = {OP_ORI, bus.rs_i, bus.rt_i, bus.imm_i};
         3'd3: enc_word = {OP_BEQ, bus.rs_i, bus.rt_i, bus.imm_i};
         3'd4: enc_word = {OP_LW, bus.rs_i, bus.rt_i, bus.imm_i};
         3'd5: enc_word = {OP_SW, bus.rs_i, bus.rt_i, bus.imm_i};
         3'd6: enc_word = {OP_J, bus.target_i};
         default: enc_word = '0;
      endcase
   end

   // Window state register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Window transitions. The last slot is recognised from the word count
   // rather than the address so a non-zero BASE_ADDR wraps correctly; the
   // move to FULL happens on the accept itself so ready drops immediately.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start_i) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            if (bus.start_i)                           state_d = ST_LOAD;
            else if (bus.stop_i)                       state_d = ST_IDLE;
            else if (write_en && (cnt_q == CNT_LAST))  state_d = ST_FULL;
         end
         ST_FULL: begin
            if (bus.start_i)     state_d = ST_LOAD;
            else if (bus.stop_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Write port and window pointer. An accepted word is registered so the
   // strobe appears exactly one cycle later; address/data hold afterwards.
   // Start cannot coincide with write_en, so pointer reload never races it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         we_q    <= 1'b0;
         addr_q  <= BASE;
         wdata_q <= '0;
         ptr_q   <= BASE;
         cnt_q   <= '0;
      end else begin
         we_q <= write_en;
         if (write_en) begin
            addr_q  <= ptr_q;
            wdata_q <= enc_word;
            ptr_q   <= ptr_q + 1'b1;
            if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
         end
         if (bus.start_i) begin
            ptr_q <= BASE;
            cnt_q <= '0;
         end
      end
   end

`ifdef ENCODER_CHECK_EN
   logic [7:0] err_q;

   // Dropped-request counter, saturating, cleared with each new window.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_q <= '0;
      end else if (bus.start_i) begin
         err_q <= '0;
      end else if (drop && (err_q != 8'hFF)) begin
         err_q <= err_q + 1'b1;
      end
   end

   assign bus.err_cnt_o = err_q;
`else
   assign bus.err_cnt_o = '0;
`endif

   assign bus.req_ready_o = req_ready;
   assign bus.mem_we_o    = we_q;
   assign bus.mem_addr_o  = addr_q;
   assign bus.mem_wdata_o = wdata_q;
   assign bus.count_o     = cnt_q;
   assign bus.busy_o      = (state_q != ST_IDLE);

endmodule
